// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
//   Coin-return sequencer. Accepts a change amount in farthings and pays it out
//   one coin at a time. Ha'pennies (2 farthings) are paid before farthings (1).
//   Each coin is requested from the mechanism with a req/ack handshake. After
//   each acknowledged coin, the block waits GAP_CYC idle cycles.
//
//   Optional feature: define CHANGE_TIMEOUT_EN to abandon a request (and pulse
//   fault) after TIMEOUT_CYC cycles without coin_ack.
//
// Ports
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   start, amount   begin dispensing `amount` farthings (sampled in IDLE only)
//   reload          reload both inventories to their INIT values (IDLE only)
//   coin_ack        mechanism has released the requested coin
//   hp_req, f_req   request one ha'penny / one farthing (also drive the LEDs)
//   busy            high whenever not IDLE
//   done, fault     one-cycle completion / early-stop pulses
//   remaining       farthings still owed
//   hp_count,f_count coin inventories
//   seg             active-low 7-segment digit of remaining (seg[0]=a .. seg[6]=g)
module change_dispense_ctrl #(
  parameter int HP_INIT     = 8,
  parameter int F_INIT      = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       reload,
  input  logic       coin_ack,
  output logic       hp_req,
  output logic       f_req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining,
  output logic [7:0] hp_count,
  output logic [7:0] f_count,
  output logic [6:0] seg
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ_H,
    ST_REQ_F,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [7:0]  HP_INIT_V = 8'(HP_INIT);
  localparam logic [7:0]  F_INIT_V  = 8'(F_INIT);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
`ifdef CHANGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
`endif

  if (GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("change_dispense_ctrl: GAP_CYC and TIMEOUT_CYC must be >= 1");
  end

  state_t      state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [7:0]  hp_q, hp_d;
  logic [7:0]  f_q, f_d;
  // Shared cycle counter: GAP length and (optionally) request timeout.
  // It clears whenever the state changes, so every state starts counting at 0.
  logic [15:0] cnt_q, cnt_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      hp_q    <= HP_INIT_V;
      f_q     <= F_INIT_V;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hp_q    <= hp_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hp_d    = hp_q;
    f_d     = f_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = amount;
          state_d = ST_SELECT;
        end else if (reload) begin
          hp_d = HP_INIT_V;
          f_d  = F_INIT_V;
        end
      end
      ST_SELECT: begin
        if (rem_q == 4'd0)                       state_d = ST_DONE;
        else if (rem_q >= 4'd2 && hp_q != 8'd0)  state_d = ST_REQ_H;
        else if (f_q != 8'd0)                    state_d = ST_REQ_F;
        else                                     state_d = ST_FAULT;
      end
      ST_REQ_H: begin
        if (coin_ack) begin
          rem_d   = rem_q - 4'd2;
          hp_d    = hp_q - 8'd1;
          state_d = ST_GAP;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) state_d = ST_FAULT;
        else                       cnt_d   = cnt_q + 16'd1;
`endif
      end
      ST_REQ_F: begin
        if (coin_ack) begin
          rem_d   = rem_q - 4'd1;
          f_d     = f_q - 8'd1;
          state_d = ST_GAP;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) state_d = ST_FAULT;
        else                       cnt_d   = cnt_q + 16'd1;
`endif
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_SELECT;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; requests decode straight from state so reset drops them at once
  always_comb begin
    hp_req    = (state_q == ST_REQ_H);
    f_req     = (state_q == ST_REQ_F);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    fault     = (state_q == ST_FAULT);
    remaining = rem_q;
    hp_count  = hp_q;
    f_count   = f_q;
    seg       = 7'b1111111;
    unique case (rem_q)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
